// File: rtl/gshare_predict_unit_pkg.sv
// Shared parameters and branch bundles for the gshare predictor.
// Check/update bundles travel between the IF predictor and EX resolution.
package RVS192_user_parameters;
  localparam int GSHARE_HISTORY_LENGTH = 8;
  localparam int PC_LENGTH = 32;
endpackage

package RVS192_package;
  import RVS192_user_parameters::*;

  typedef enum logic {
    INIT,
    RUN
  } pht_state_type;

  typedef struct packed {
    logic [1:0]                       GBP_predict;
    logic [GSHARE_HISTORY_LENGTH-1:0] GBHR;
    logic                             branch_take;
  } br_check_type;

  typedef struct packed {
    logic                             update;
    logic                             actual;
    logic                             wrong;
    logic [1:0]                       GBP_predict_update;
    logic [GSHARE_HISTORY_LENGTH-1:0] GBHR_old;
  } br_update_type;
endpackage

// File: rtl/gshare_predict_unit_pht_ram.sv
// Pattern history table: async read, sync write, write-to-read bypass.
// Contents are not reset; the owner sweeps them after reset.
module pht_ram #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] waddr,
  input  logic [1:0]   wdata,
  input  logic [N-1:0] raddr,
  output logic [1:0]   rdata
);

  logic [1:0] mem [2**N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = mem[raddr];
    if (we && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/gshare_predict_unit.sv
// Fetch-stage gshare predictor: PHT, speculative and committed GHR,
// plus the post-reset table initialisation sweep.
module gshare_predict_unit
  import RVS192_user_parameters::*;
  import RVS192_package::*;
#(
  parameter logic [1:0] PHT_INIT = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_LENGTH-1:0] pc_if,
  input  logic                 fetch_valid,
  input  logic                 stall_if,
  input  logic                 branch_hint_if,
  output br_check_type         br_check_if,
  output logic                 ready,
  input  br_update_type        br_update_ex,
  input  logic [PC_LENGTH-1:0] pc_ex
);

  localparam int N = GSHARE_HISTORY_LENGTH;

  pht_state_type state;
  logic [N-1:0]  cnt;
  logic [N-1:0]  spec_ghr;
  logic [N-1:0]  committed_ghr;

  logic [N-1:0]  idx_if;
  logic [N-1:0]  idx_ex;
  logic [1:0]    pht_rd;
  logic          wr_en;
  logic [N-1:0]  wr_addr;
  logic [1:0]    wr_data;
  logic          run;
  logic          advance;
  logic          repair;

  assign run     = (state == RUN);
  assign idx_if  = pc_if[N+1:2] ^ spec_ghr;
  assign idx_ex  = pc_ex[N+1:2] ^ br_update_ex.GBHR_old;
  assign repair  = run && br_update_ex.update && br_update_ex.wrong;
  assign advance = run && fetch_valid && branch_hint_if && !stall_if;

  // The sweep owns the write port until RUN; EX updates are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!rst) begin
      if (!run) begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = PHT_INIT;
      end else if (br_update_ex.update) begin
        wr_en   = 1'b1;
        wr_addr = idx_ex;
        wr_data = br_update_ex.GBP_predict_update;
      end
    end
  end

  pht_ram #(
    .N (N)
  ) u_pht (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_if),
    .rdata (pht_rd)
  );

  always_comb begin
    br_check_if = '0;
    if (run) begin
      br_check_if.GBP_predict = pht_rd;
      br_check_if.GBHR        = spec_ghr;
      br_check_if.branch_take = pht_rd[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      cnt           <= '0;
      ready         <= 1'b0;
      spec_ghr      <= '0;
      committed_ghr <= '0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + N'(1);
          if (cnt == {N{1'b1}}) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (br_update_ex.update)
            committed_ghr <= {br_update_ex.GBHR_old[N-2:0],
                              br_update_ex.actual};
          // A mispredict flushes the fetch, so repair wins.
          if (repair)
            spec_ghr <= {br_update_ex.GBHR_old[N-2:0],
                         br_update_ex.actual};
          else if (advance)
            spec_ghr <= {spec_ghr[N-2:0], pht_rd[1]};
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pc_if[PC_LENGTH-1:N+2], pc_if[1:0],
                       pc_ex[PC_LENGTH-1:N+2], pc_ex[1:0],
                       br_update_ex.GBHR_old[N-1], committed_ghr};

endmodule

// File: tb/tb_gshare_predict_unit.sv
// Directed bench for the gshare predictor: sweep, training,
// bypass, speculative history, repair priority and mid-sweep reset.
module tb_gshare_predict_unit;
  import RVS192_user_parameters::*;
  import RVS192_package::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [PC_LENGTH-1:0] pc_if;
  logic                 fetch_valid;
  logic                 stall_if;
  logic                 branch_hint_if;
  br_check_type         br_check_if;
  logic                 ready;
  br_update_type        br_update_ex;
  logic [PC_LENGTH-1:0] pc_ex;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  gshare_predict_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_if          (pc_if),
    .fetch_valid    (fetch_valid),
    .stall_if       (stall_if),
    .branch_hint_if (branch_hint_if),
    .br_check_if    (br_check_if),
    .ready          (ready),
    .br_update_ex   (br_update_ex),
    .pc_ex          (pc_ex)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit inject);
    n = 0;
    while (!ready && n < 600) begin
      br_update_ex = '0;
      pc_ex = '0;
      if (inject && n == 10) begin
        br_update_ex.update             = 1'b1;
        br_update_ex.actual             = 1'b1;
        br_update_ex.GBP_predict_update = 2'b11;
      end
      n++;
      tick();
    end
    br_update_ex = '0;
  endtask

  initial begin
    rst            = 1'b1;
    pc_if          = '0;
    fetch_valid    = 1'b0;
    stall_if       = 1'b0;
    branch_hint_if = 1'b0;
    br_update_ex   = '0;
    pc_ex          = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_check", br_check_if, 0);

    sweep(1'b1);
    chk("sweep_len", n, 256);

    pc_if = 32'h0;
    #1;
    chk("idle_pred0", br_check_if.GBP_predict, 2'b01);
    chk("idle_take0", br_check_if.branch_take, 0);
    chk("idle_ghr", br_check_if.GBHR, 0);
    chk("init_upd_ghr", dut.committed_ghr, 0);
    pc_if = 32'h3fc;
    #1;
    chk("idle_predff", br_check_if.GBP_predict, 2'b01);

    // Train index 0x10 to strongly taken
    br_update_ex.update             = 1'b1;
    br_update_ex.actual             = 1'b1;
    br_update_ex.GBP_predict_update = 2'b11;
    br_update_ex.GBHR_old           = '0;
    pc_ex = 32'h40;
    pc_if = 32'h40;
    #1;
    chk("bypass_pred", br_check_if.GBP_predict, 2'b11);
    chk("bypass_take", br_check_if.branch_take, 1);
    pc_if = 32'h44;
    #1;
    chk("other_idx", br_check_if.GBP_predict, 2'b01);
    tick();
    br_update_ex = '0;
    pc_if = 32'h40;
    #1;
    chk("trained_pred", br_check_if.GBP_predict, 2'b11);
    chk("trained_take", br_check_if.branch_take, 1);
    chk("commit_ghr1", dut.committed_ghr, 8'h01);
    chk("spec_ghr0", br_check_if.GBHR, 0);

    // Pick PCs so each fetch lands on trained index 0x10
    fetch_valid    = 1'b1;
    branch_hint_if = 1'b1;
    pc_if = 32'h40;
    #1 chk("adv_take0", br_check_if.branch_take, 1);
    tick();
    pc_if = 32'h44;
    #1 chk("adv_take1", br_check_if.branch_take, 1);
    tick();
    pc_if = 32'h4c;
    #1 chk("adv_take2", br_check_if.branch_take, 1);
    tick();
    pc_if    = 32'h5c;
    stall_if = 1'b1;
    #1 chk("adv_ghr3", br_check_if.GBHR, 8'h07);
    tick();
    chk("stall_ghr", br_check_if.GBHR, 8'h07);
    stall_if       = 1'b0;
    branch_hint_if = 1'b0;
    tick();
    chk("nohint_ghr", br_check_if.GBHR, 8'h07);
    branch_hint_if = 1'b1;
    fetch_valid    = 1'b0;
    tick();
    chk("novalid_ghr", br_check_if.GBHR, 8'h07);

    // Repair against a concurrent taken, hinted fetch
    fetch_valid = 1'b1;
    pc_if       = 32'h5c;
    br_update_ex.update             = 1'b1;
    br_update_ex.wrong              = 1'b1;
    br_update_ex.actual             = 1'b0;
    br_update_ex.GBHR_old           = 8'h03;
    br_update_ex.GBP_predict_update = 2'b00;
    pc_ex = 32'h100;
    #1 chk("rep_fetch_take", br_check_if.branch_take, 1);
    tick();
    br_update_ex   = '0;
    fetch_valid    = 1'b0;
    branch_hint_if = 1'b0;
    chk("repair_ghr", br_check_if.GBHR, 8'h06);
    chk("repair_commit", dut.committed_ghr, 8'h06);
    pc_if = 32'h114;
    #1 chk("repair_pht", br_check_if.GBP_predict, 2'b00);

    // Reset partway through a sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ready", ready, 0);
    chk("rst2_check", br_check_if, 0);
    repeat (100) tick();
    chk("mid_ready", ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep(1'b0);
    chk("resweep_len", n, 256);
    pc_if = 32'h40;
    #1 chk("resweep_pred", br_check_if.GBP_predict, 2'b01);
    chk("resweep_ghr", br_check_if.GBHR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_predict_unit.md
Name: gshare_predict_unit

Overview:
- Fetch-stage gshare direction predictor. It is the producer of `br_check_type` and the consumer of `br_update_type` emitted by EX branch resolution.
- Holds the pattern history table (PHT) of 2-bit counters, a speculative global history register (spec GHR) and a committed GHR.
- Predicts in IF, trains and repairs history from EX updates, and runs a post-reset table-initialisation sweep.

Parameters:
- `GSHARE_HISTORY_LENGTH`, 8: GHR width and PHT index width; the PHT has 2^N entries.
- `PC_LENGTH`, 32: PC width.
- `PHT_INIT`, 2'b01: counter value written to every entry by the init sweep.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_if`  in  PC_LENGTH  fetch PC.
- `fetch_valid`  in  1  `pc_if` is valid this cycle.
- `stall_if`  in  1  IF stalled; no history advance.
- `branch_hint_if`  in  1  pre-decode marks the fetched word as a conditional or unconditional branch.
- `br_check_if`  out  br_check_type  fields: `GBP_predict[1:0]`, `GBHR[N-1:0]`, `branch_take`.
- `ready`  out  1  init sweep finished.
- `br_update_ex`  in  br_update_type  fields used: `update`, `actual`, `wrong`, `GBP_predict_update[1:0]`, `GBHR_old[N-1:0]`.
- `pc_ex`  in  PC_LENGTH  PC of the resolving branch.

Behaviour:
- Clocking: single clock `clk`; `rst` is synchronous and active-high. All state changes occur on the rising edge.
- Reset (edge with `rst`=1):
  - FSM enters INIT; sweep counter = 0; `ready` = 0.
  - Spec GHR and committed GHR = 0.
  - PHT contents are don't-care until the sweep completes.
- FSM:
  - INIT: each cycle write `PHT[cnt]` = `PHT_INIT`, then cnt++.
  - When cnt = 2^N-1 is written, go to RUN; `ready` = 1 from the next cycle. The sweep takes exactly 2^N cycles.
  - RUN: normal operation; it stays in RUN until `rst`.
  - `rst` asserted mid-sweep restarts the sweep at 0.
- Outputs while INIT:
  - `br_check_if` = all zero, so `branch_take` = 0.
  - `br_update_ex` is ignored: no PHT write, no GHR change.
- Prediction (combinational, zero latency from `pc_if`):
  - `idx_if = pc_if[N+1:2] ^ spec_GHR`.
  - `GBP_predict = PHT[idx_if]`.
  - `GBHR = spec_GHR`.
  - `branch_take = GBP_predict[1]`.
- Read-after-write bypass: if a PHT write in the same cycle targets `idx_if`, `GBP_predict` returns the value being written.
- Training (RUN, `br_update_ex.update` = 1):
  - `idx_ex = pc_ex[N+1:2] ^ GBHR_old`.
  - `PHT[idx_ex] <= GBP_predict_update`.
  - `committed_GHR <= {GBHR_old[N-2:0], actual}`.
- Speculative history advance: when RUN, `fetch_valid`, `branch_hint_if` and not `stall_if`, `spec_GHR <= {spec_GHR[N-2:0], branch_take}`.
- Repair: when RUN, `update` and `wrong`, `spec_GHR <= {GBHR_old[N-2:0], actual}`.
  - Repair has priority over a same-cycle speculative advance; the fetched instruction is being flushed.
- Simultaneous training write and prediction read on different indices: both proceed.
- Arithmetic:
  - Index XOR is N bits wide; only PC bits `[N+1:2]` are used.
  - PHT counters are stored exactly as supplied; saturation is done upstream.
  - GHR shifts drop the MSB.

Decomposition:
- `RVS192_package`: `br_check_type` and `br_update_type` (gshare fields), plus the FSM enum `pht_state_type` {INIT, RUN}.
- `RVS192_user_parameters`: `GSHARE_HISTORY_LENGTH` and `PC_LENGTH`.
- One sub-module: `pht_ram`, 2^N x 2 flops with one async read port, one sync write port and internal write-to-read bypass. The GHR registers and FSM stay in the top module.

Test Plan:
- Reset then idle:
  - `ready` = 0 for exactly 256 cycles (N=8), then 1.
  - Any `pc_if` then gives `GBP_predict`=01, `branch_take`=0, `GBHR`=0.
- Update during INIT:
  - Drive `update`=1, `GBP_predict_update`=11 at cycle 10.
  - After the sweep that entry still reads 01, and committed GHR = 0.
- Train and predict:
  - RUN, GHR=0, `pc_ex`=0x40, update with `GBP_predict_update`=11, `actual`=1.
  - Next cycle `pc_if`=0x40 with the GHR repaired to 0 reads 11 and `branch_take`=1.
  - Same-cycle read of index 0x10 returns 11 via the bypass.
- Speculative advance and stall:
  - 3 hinted fetches predicted taken give spec GHR = 0x07.
  - A 4th with `stall_if`=1 leaves 0x07.
  - Unhinted fetches leave it unchanged.
- Mispredict repair priority:
  - spec GHR=0x07, `update`=1, `wrong`=1, `GBHR_old`=0x03, `actual`=0, with a concurrent hinted fetch.
  - Next spec GHR = 0x06, not 0x0F.
- Reset mid-sweep: assert `rst` at sweep cycle 100; `ready` stays 0 for 256 further cycles.
